// File: rtl/ps2_host_tx.sv
// ps2_host_tx: Z80 I/O register driving host-to-device PS/2 commands on shared open-drain lines.
// Latency: accepted write -> INHIBIT_CYCLES clock hold, start bit, 10 device clocks, ack, DONE (intr_out).
// Backpressure: writes while busy are dropped and flagged OVR; define PS2_TX_RETRY_EN for 2 extra tries.
module ps2_host_tx #(
  parameter int REG_ADDR       = 6,
  parameter int INHIBIT_CYCLES = 480,
  parameter int TIMEOUT_CYCLES = 60000,
  parameter int SYNC_STAGES    = 4
) (
  input  logic       cpuclk,
  input  logic       nrst,
  inout  wire  [7:0] data,
  input  logic       ncs,
  input  logic       nwr,
  input  logic       nrd,
  input  logic [3:0] addr,
  inout  wire        ps2clk,
  inout  wire        ps2data,
  output logic       busy,
  output logic       intr_out
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_SHIFT, S_ACK, S_WAITIDLE, S_DONE
  } state_t;

  state_t                 r_state, w_next;
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic                   r_clk_f;
  logic [1:0]             r_dat_sync;
  logic                   r_wr_seen, r_rd_prev;
  logic [7:0]             r_byte;
  logic                   r_par, r_dout;
  logic [3:0]             r_idx;
  logic [INH_W-1:0]       r_inh;
  logic [TMO_W-1:0]       r_tmo;
  logic                   r_done, r_ovr, r_tout, r_nack, r_intr;

  logic w_wr_sel, w_rd_sel, w_wr_stb, w_accept, w_rd_rel;
  logic w_fall, w_clk_hi, w_dat_s;
  logic w_clk_low, w_dat_low, w_timed, w_nack_evt, w_tout_evt;
  logic w_can_retry, w_retry_pend;
  logic [7:0] w_status;

  assign w_wr_sel = !ncs && !nwr && (addr == 4'(REG_ADDR));
  assign w_rd_sel = !ncs && !nrd && (addr == 4'(REG_ADDR));
  // r_wr_seen follows the strobe, so only the first cycle of a held strobe counts
  assign w_wr_stb = w_wr_sel && !r_wr_seen;
  assign w_accept = w_wr_stb && (r_state == S_IDLE);
  assign w_rd_rel = r_rd_prev && !w_rd_sel;

  // Device clock edge: every filter stage low while the filtered level was still high
  assign w_fall   = r_clk_f && (r_clk_sync == '0);
  assign w_clk_hi = &r_clk_sync;
  assign w_dat_s  = r_dat_sync[1];

  assign busy     = (r_state != S_IDLE) && (r_state != S_DONE);
  assign intr_out = r_intr;
  assign w_status = {r_done, 3'b000, r_ovr, r_tout, r_nack, busy};

  // Lines are only ever pulled low; the high level comes from the bus pull-ups
  assign data    = w_rd_sel  ? w_status : 8'hzz;
  assign ps2clk  = w_clk_low ? 1'b0 : 1'bz;
  assign ps2data = w_dat_low ? 1'b0 : 1'bz;

  // State register
  always_ff @(posedge cpuclk or negedge nrst) begin
    if (!nrst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state, line pull-downs and error events
  always_comb begin
    w_next     = r_state;
    w_clk_low  = 1'b0;
    w_dat_low  = 1'b0;
    w_timed    = 1'b0;
    w_nack_evt = 1'b0;
    w_tout_evt = 1'b0;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = S_INHIBIT;
      S_INHIBIT: begin
        w_clk_low = 1'b1;
        if (r_inh == '0) begin
          w_dat_low = 1'b1;
          w_next    = S_START;
        end
      end
      S_START:   begin
        w_dat_low = 1'b1;
        w_next    = S_SHIFT;
      end
      S_SHIFT:   begin
        w_timed   = 1'b1;
        w_dat_low = !r_dout;
        if (w_fall && (r_idx == 4'd10)) w_next = S_ACK;
      end
      S_ACK:     begin
        w_timed = 1'b1;
        if (w_fall) begin
          w_nack_evt = w_dat_s;
          w_next     = S_WAITIDLE;
        end
      end
      S_WAITIDLE: begin
        w_timed = 1'b1;
        if (w_clk_hi && w_dat_s) w_next = w_retry_pend ? S_INHIBIT : S_DONE;
      end
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
    // A stalled device overrides whatever the state was doing
    if (w_timed && (r_tmo == '0)) begin
      w_clk_low  = 1'b0;
      w_dat_low  = 1'b0;
      w_nack_evt = 1'b0;
      w_tout_evt = 1'b1;
      w_next     = w_can_retry ? S_INHIBIT : S_DONE;
    end
  end

`ifdef PS2_TX_RETRY_EN
  logic [1:0] r_try;
  logic       r_retry_pend;
  assign w_can_retry  = (r_try != 2'd2);
  assign w_retry_pend = r_retry_pend;

  // Attempt counter; a NACK retry waits for the device to release the lines first
  always_ff @(posedge cpuclk or negedge nrst) begin
    if (!nrst) begin
      r_try        <= 2'd0;
      r_retry_pend <= 1'b0;
    end else begin
      if (w_accept) r_try <= 2'd0;
      else if ((w_nack_evt || w_tout_evt) && w_can_retry) r_try <= r_try + 2'd1;
      if (r_state == S_INHIBIT) r_retry_pend <= 1'b0;
      else if (w_nack_evt && w_can_retry) r_retry_pend <= 1'b1;
    end
  end
`else
  assign w_can_retry  = 1'b0;
  assign w_retry_pend = 1'b0;
`endif

  // Line synchronisers, CPU strobe tracking, counters, shifter and status flags
  always_ff @(posedge cpuclk or negedge nrst) begin
    if (!nrst) begin
      r_clk_sync <= '1;
      r_clk_f    <= 1'b1;
      r_dat_sync <= 2'b11;
      r_wr_seen  <= 1'b0;
      r_rd_prev  <= 1'b0;
      r_byte     <= 8'h00;
      r_par      <= 1'b0;
      r_dout     <= 1'b1;
      r_idx      <= 4'd0;
      r_inh      <= '0;
      r_tmo      <= '0;
      r_done     <= 1'b0;
      r_ovr      <= 1'b0;
      r_tout     <= 1'b0;
      r_nack     <= 1'b0;
      r_intr     <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2clk};
      if (r_clk_sync == '0) r_clk_f <= 1'b0;
      else if (w_clk_hi)    r_clk_f <= 1'b1;
      r_dat_sync <= {r_dat_sync[0], ps2data};
      r_wr_seen  <= w_wr_sel;
      r_rd_prev  <= w_rd_sel;

      if (w_accept) begin
        r_byte <= data;
        r_par  <= ~^data;
      end

      if (r_state != S_INHIBIT) r_inh <= INH_W'(INHIBIT_CYCLES - 1);
      else if (r_inh != '0)     r_inh <= r_inh - INH_W'(1);

      if ((r_state == S_INHIBIT) || (r_state == S_START) || w_fall)
        r_tmo <= TMO_W'(TIMEOUT_CYCLES - 1);
      else if (r_tmo != '0)
        r_tmo <= r_tmo - TMO_W'(1);

      // idx counts falling edges seen; the bit presented after edge n is frame bit n-1
      if (r_state == S_START) begin
        r_idx  <= 4'd0;
        r_dout <= 1'b0;
      end else if ((r_state == S_SHIFT) && w_fall) begin
        if (r_idx < 4'd8)       r_dout <= r_byte[r_idx[2:0]];
        else if (r_idx == 4'd8) r_dout <= r_par;
        else                    r_dout <= 1'b1;
        if (r_idx != 4'd10) r_idx <= r_idx + 4'd1;
      end

      if (w_accept) r_nack <= 1'b0;
      else if (w_nack_evt && !w_can_retry) r_nack <= 1'b1;
      if (w_accept) r_tout <= 1'b0;
      else if (w_tout_evt && !w_can_retry) r_tout <= 1'b1;

      if (w_wr_stb && busy) r_ovr <= 1'b1;
      else if (w_rd_rel)    r_ovr <= 1'b0;

      // Completion setting wins over a simultaneous read release
      if (r_state == S_DONE) begin
        r_done <= 1'b1;
        r_intr <= 1'b1;
      end else if (w_rd_rel) begin
        r_done <= 1'b0;
        r_intr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: Z80-style register accesses plus a PS/2 keyboard model on pulled-up lines.
// Device clock is 12.5 kHz (160 cpuclk cycles per half period); frames are captured on rising edges.
// Each step is a directed vector with hand-computed expected values.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int HALF = 160;

  logic       cpuclk = 1'b0;
  logic       nrst = 1'b0;
  logic       ncs = 1'b1, nwr = 1'b1, nrd = 1'b1;
  logic [3:0] addr = 4'd0;
  logic [7:0] tb_dat = 8'h00;
  logic       tb_dat_oe = 1'b0;
  logic       bfm_clk_low = 1'b0, bfm_dat_low = 1'b0;
  wire  [7:0] data;
  wire        ps2clk, ps2data;
  logic       busy, intr_out;
  int         vectors = 0, miscompares = 0;
  int         cyc_cnt = 0;
  int         wr_start = 0;
  logic [7:0] st;

  assign data    = tb_dat_oe ? tb_dat : 8'hzz;
  assign ps2clk  = bfm_clk_low ? 1'b0 : 1'bz;
  assign ps2data = bfm_dat_low ? 1'b0 : 1'bz;
  pullup (ps2clk);
  pullup (ps2data);

  ps2_host_tx dut (
    .cpuclk(cpuclk), .nrst(nrst), .data(data), .ncs(ncs), .nwr(nwr), .nrd(nrd),
    .addr(addr), .ps2clk(ps2clk), .ps2data(ps2data), .busy(busy), .intr_out(intr_out)
  );

  always #125 cpuclk = ~cpuclk;
  always @(posedge cpuclk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge cpuclk);
  endtask

  // Two-cycle write strobe; wr_start is the cycle whose rising edge accepts it
  task automatic cpu_write(input logic [7:0] b);
    addr = 4'd6; tb_dat = b; tb_dat_oe = 1'b1; ncs = 1'b0; nwr = 1'b0;
    wr_start = cyc_cnt + 1;
    cyc(2);
    nwr = 1'b1; ncs = 1'b1; tb_dat_oe = 1'b0;
    cyc(1);
  endtask

  task automatic cpu_read(output logic [7:0] v);
    addr = 4'd6; ncs = 1'b0; nrd = 1'b0;
    cyc(1);
    v = data;
    nrd = 1'b1; ncs = 1'b1;
    cyc(1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 8000) begin cyc(1); n++; end
    chk({tag, " busy drop"}, busy, 0);
    cyc(2);
  endtask

  // Keyboard model: times the inhibit, checks the start bit, then gives n_falls clocks.
  // inh_start < 0 means the inhibit is timed from the first low level seen.
  task automatic bfm(input string tag, input logic [9:0] exp_frame, input bit nack,
                     input int inh_start, input int n_falls);
    int n, t0;
    logic [9:0] got = '0;
    n = 0;
    while (ps2clk !== 1'b0 && n < 2000) begin cyc(1); n++; end
    t0 = (inh_start >= 0) ? inh_start : cyc_cnt;
    n = 0;
    while (ps2clk === 1'b0 && n < 2000) begin cyc(1); n++; end
    chk({tag, " inhibit length"}, cyc_cnt - t0, 480);
    chk({tag, " start bit"}, ps2data, 0);
    cyc(HALF);
    for (int k = 1; k <= n_falls; k++) begin
      bfm_clk_low = 1'b1;
      cyc(HALF);
      bfm_clk_low = 1'b0;
      if (k <= 10) got[k-1] = ps2data;
      if (k == 10 && !nack) bfm_dat_low = 1'b1;
      if (k == 12) bfm_dat_low = 1'b0;
      if (k < n_falls) cyc(HALF);
    end
    if (n_falls == 12) chk({tag, " frame"}, got, exp_frame);
  endtask

  initial begin
    int s55;
    // Reset state
    cyc(3);
    chk("reset busy", busy, 0);
    chk("reset intr", intr_out, 0);
    chk("reset ps2clk", ps2clk, 1);
    chk("reset ps2data", ps2data, 1);
    nrst = 1'b1;
    cyc(2);
    cpu_read(st); chk("reset status", st, 8'h00);

    // 0xED, ACK: data 1,0,1,1,0,1,1,1, parity 1, stop 1
    cpu_write(8'hED);
    chk("ED busy", busy, 1);
    bfm("ED", 10'h3ED, 1'b0, wr_start, 12);
    wait_idle("ED");
    chk("ED intr", intr_out, 1);
    cpu_read(st); chk("ED status", st, 8'h80);
    chk("ED intr cleared", intr_out, 0);
    cpu_read(st); chk("ED status cleared", st, 8'h00);

    // 0xFF with NACK; status read mid-transfer shows only busy
    cpu_write(8'hFF);
    cpu_read(st); chk("FF status busy", st, 8'h01);
`ifdef PS2_TX_RETRY_EN
    bfm("FF try1", 10'h3FF, 1'b1, wr_start, 12);
    bfm("FF try2", 10'h3FF, 1'b1, -1, 12);
    bfm("FF try3", 10'h3FF, 1'b0, -1, 12);
    wait_idle("FF");
    chk("FF intr", intr_out, 1);
    cpu_read(st); chk("FF status retry", st, 8'h80);
`else
    bfm("FF", 10'h3FF, 1'b1, wr_start, 12);
    wait_idle("FF");
    chk("FF intr", intr_out, 1);
    cpu_read(st); chk("FF status nack", st, 8'h82);

    // 0xF3 to a silent device: timeout 60000 cycles after the start bit
    cpu_write(8'hF3);
    bfm("F3", 10'h000, 1'b0, wr_start, 0);
    while (cyc_cnt < wr_start + 60400) cyc(1);
    chk("F3 busy before tout", busy, 1);
    chk("F3 start bit held", ps2data, 0);
    while (cyc_cnt < wr_start + 60600) cyc(1);
    chk("F3 busy after tout", busy, 0);
    chk("F3 ps2clk released", ps2clk, 1);
    chk("F3 ps2data released", ps2data, 1);
    chk("F3 intr", intr_out, 1);
    cpu_read(st); chk("F3 status tout", st, 8'h84);
`endif

    // 0x55 then 0xAA while busy: 0x55 sent intact, overrun flagged
    cpu_write(8'h55);
    s55 = wr_start;
    cpu_write(8'hAA);
    chk("55 busy", busy, 1);
    bfm("55", 10'h355, 1'b0, s55, 12);
    wait_idle("55");
    cpu_read(st); chk("55 status ovr", st, 8'h88);
    cpu_read(st); chk("55 status cleared", st, 8'h00);

    // Reset while data bit 4 (a 0 of byte 0x00) is on the line
    cpu_write(8'h00);
    bfm("rst", 10'h000, 1'b0, wr_start, 5);
    chk("rst bit4 driven", ps2data, 0);
    nrst = 1'b0;
    #1;
    chk("rst ps2data", ps2data, 1);
    chk("rst ps2clk", ps2clk, 1);
    chk("rst busy", busy, 0);
    chk("rst intr", intr_out, 0);
    cyc(2);
    nrst = 1'b1;
    cyc(2);
    cpu_read(st); chk("rst status", st, 8'h00);

    // Next write after reset, 0x07: parity 0
    cpu_write(8'h07);
    bfm("07", 10'h207, 1'b0, wr_start, 12);
    wait_idle("07");
    cpu_read(st); chk("07 status", st, 8'h80);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
